dados_ram_param: RTL and testbench
==================================

Name: dados_ram_param

Overview:
Parametrised successor of the processor's data RAM, on a single clock with an asynchronous active-low reset. Byte-addressable single-port data memory supporting byte, half-word and word load/store with sign or zero extension. It also provides a programmable base-offset register, alignment and range error detection, configurable read latency, write-first read-during-write, and an optional zero-clear sweep after reset. It sits between the processor's memory stage and the word-organised storage array.

Parameters:
DATA_WIDTH, 32, word width in bits; fixed at 32 for the size encodings below.
ADDR_WIDTH, 32, byte address and offset width.
DEPTH, 2048, number of words.
READ_LATENCY, 1, cycles from accepted read to q_valid; legal values 1 or 2.
CLEAR_ON_RESET, 1, when 1, zero every word after reset release.

Ports:
clock  in  1  single clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
re  in  1  read request.
we  in  1  write request.
endereco  in  ADDR_WIDTH  byte address, before offset.
tamanho  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
sinal  in  1  1 = sign-extend loads, 0 = zero-extend.
data  in  DATA_WIDTH  store data, right-aligned.
set_offset  in  1  load the offset register.
offset  in  ADDR_WIDTH  new offset value.
q  out  DATA_WIDTH  load result.
q_valid  out  1  one-cycle pulse marking q valid.
erro_alinhamento  out  1  one-cycle pulse on a misaligned access.
erro_limite  out  1  one-cycle pulse on an out-of-range access.
ocupado  out  1  high while the clear sweep runs.

Behaviour:
- Reset (async, reset_n = 0):
  - q = 0, q_valid = 0, both error outputs = 0, offset register = 0.
  - State = LIMPANDO with sweep counter 0 if CLEAR_ON_RESET = 1, else PRONTO.
  - ocupado = CLEAR_ON_RESET.
  - Array contents are not reset.
- Effective address: ea = endereco + offset register, modulo 2^ADDR_WIDTH. Word index = ea[ADDR_WIDTH-1:2]; lane = ea[1:0].
- Offset register:
  - set_offset loads offset at the edge.
  - An access in the same cycle uses the old offset.
  - set_offset is accepted in every state, including LIMPANDO.
- FSM:
  - LIMPANDO: writes 0 to word[counter] each cycle and increments the counter. After the counter reaches DEPTH-1, the state moves to PRONTO, so ocupado is high for exactly DEPTH cycles after reset release.
  - LIMPANDO: re and we are ignored; no q_valid and no error pulses are produced.
  - PRONTO: normal access. There is no exit except reset, and reset mid-sweep restarts the sweep at 0.
- Access checks (PRONTO, re or we high):
  - Misaligned: half with ea[0] = 1, or word with ea[1:0] ≠ 00. Misalignment has priority over the range check.
  - Out of range: word index ≥ DEPTH.
  - On either error: the matching error output pulses 1 cycle after the access, the write is suppressed, and a read returns q = 0 with q_valid still pulsing at normal latency.
- Store:
  - byte: data[7:0] goes to lane ea[1:0].
  - half: data[15:0] goes to lanes {ea[1],0} and {ea[1],1}.
  - word: all lanes.
  - Unselected bytes are preserved.
- Load:
  - The selected lane(s) are right-aligned into q.
  - Upper bits are filled with the top bit of the selection if sinal = 1, else with 0.
- Latency:
  - READ_LATENCY = 1: q and q_valid are updated at the edge after the request.
  - READ_LATENCY = 2: one extra output register stage is added.
  - q holds its last value between reads; q_valid = 0 when no read is in flight.
  - Back-to-back reads are accepted every cycle.
- re and we in the same cycle: write-first. The read returns the newly merged word (old bytes plus written lanes), then extracts per tamanho/sinal.
- Errors are reported once per access, even when re and we are both high.

Decomposition:
- Package dados_ram_pkg holds:
  - tamanho encodings TAM_BYTE, TAM_HALF, TAM_WORD;
  - the FSM enum {LIMPANDO, PRONTO};
  - a function for byte-enable generation from tamanho and lane.
- Sub-module extrator_carga (combinational): selects the lane(s) from the word and applies sign/zero extension. It is instantiated once on the read path.

Test Plan:
- Reset with CLEAR_ON_RESET = 1, DEPTH = 16 -> ocupado high for exactly 16 cycles. A word read at 0x3C afterwards returns 0x00000000, q_valid after 1 cycle.
- Word store 0x8899AABB at 0x10, byte load 0x13 with sinal = 1, then with sinal = 0 -> 0xFFFFFF88, then 0x00000088.
- Half store 0x1234 at 0x12 over 0xFFFFFFFF -> word read at 0x10 returns 0x1234FFFF.
- set_offset 0x100, then word store 0xCAFEF00D at endereco 0x4 -> word load of endereco 0x104 with offset 0 returns 0xCAFEF00D. A same-cycle set_offset plus access uses the old offset.
- Word access at 0x6 -> erro_alinhamento pulse, memory unchanged, q = 0 with q_valid. Access at word index DEPTH -> erro_limite pulse.
- re and we together with word 0x55AA55AA at 0x20, READ_LATENCY = 2 -> q = 0x55AA55AA after exactly 2 cycles. Reset asserted mid-sweep restarts ocupado for a full DEPTH cycles.

Source files
------------

// File: rtl/dados_ram_pkg.sv
// dados_ram_pkg
// Shared definitions for the data RAM: access-size encodings, the sweep/ready
// FSM state type and the byte-enable helper used on the store path.
package dados_ram_pkg;

  // tamanho encodings; 2'b11 is reserved and handled exactly like a word.
  localparam logic [1:0] TAM_BYTE = 2'b00;
  localparam logic [1:0] TAM_HALF = 2'b01;
  localparam logic [1:0] TAM_WORD = 2'b10;

  // LIMPANDO: zero-clear sweep after reset; PRONTO: normal accesses.
  typedef enum logic {
    LIMPANDO = 1'b0,
    PRONTO   = 1'b1
  } estado_t;

  // Byte lanes touched by an access of size tam starting at lane.
  // Half-words always occupy an aligned lane pair selected by lane[1].
  function automatic logic [3:0] gera_be(input logic [1:0] tam,
                                         input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b1111;
    case (tam)
      TAM_BYTE: be = 4'b0001 << lane;
      TAM_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/extrator_carga.sv
// extrator_carga
// Combinational load extractor: picks the addressed byte or half-word out of a
// storage word, right-aligns it and fills the upper bits with either the top
// bit of the selection (sign extension) or zeros.
// Ports:
//   i_palavra  storage word (already merged with any same-cycle write)
//   i_tamanho  access size (byte / half / word, reserved = word)
//   i_lane     byte lane of the effective address, ea[1:0]
//   i_sinal    1 = sign-extend, 0 = zero-extend
//   o_carga    extracted, extended load value
module extrator_carga
  import dados_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_palavra,
  input  logic [1:0]            i_tamanho,
  input  logic [1:0]            i_lane,
  input  logic                  i_sinal,
  output logic [DATA_WIDTH-1:0] o_carga
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = '0;
    w_half  = '0;
    o_carga = '0;
    case (i_tamanho)
      TAM_BYTE: begin
        case (i_lane)
          2'd0:    w_byte = i_palavra[7:0];
          2'd1:    w_byte = i_palavra[15:8];
          2'd2:    w_byte = i_palavra[23:16];
          default: w_byte = i_palavra[31:24];
        endcase
        o_carga = {{(DATA_WIDTH-8){i_sinal & w_byte[7]}}, w_byte};
      end
      TAM_HALF: begin
        // Alignment is checked upstream, so only lane[1] picks the half.
        w_half  = i_lane[1] ? i_palavra[31:16] : i_palavra[15:0];
        o_carga = {{(DATA_WIDTH-16){i_sinal & w_half[15]}}, w_half};
      end
      default: o_carga = i_palavra;
    endcase
  end

endmodule

// File: rtl/dados_ram_param.sv
// dados_ram_param
// Byte-addressable single-port data memory for the processor memory stage.
// Supports byte/half/word loads and stores with sign or zero extension, a
// programmable base offset, alignment and range error pulses, a read latency
// of 1 or 2 cycles, write-first read-during-write and an optional zero-clear
// sweep after reset.
// Ports:
//   clock, reset_n          rising-edge clock, async active-low reset
//   re, we                  read / write request (may be high together)
//   endereco                byte address before the offset is added
//   tamanho, sinal          access size and load extension mode
//   data                    right-aligned store data
//   set_offset, offset      load a new base offset (takes effect next cycle)
//   q, q_valid              load result and its one-cycle valid pulse
//   erro_alinhamento        one-cycle pulse after a misaligned access
//   erro_limite             one-cycle pulse after an out-of-range access
//   ocupado                 high while the clear sweep runs
//   estado_dbg              current FSM state, for observation only
//
// Handshake: there is no ready signal. While ocupado is low every cycle with
// re or we high is one accepted access; while ocupado is high requests are
// dropped, not stalled. q_valid is a pure valid with no back-pressure, one
// pulse per accepted read, READ_LATENCY cycles after the request edge.
module dados_ram_param
  import dados_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH          = 2048,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] endereco,
  input  logic [1:0]            tamanho,
  input  logic                  sinal,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  set_offset,
  input  logic [ADDR_WIDTH-1:0] offset,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  output logic                  erro_alinhamento,
  output logic                  erro_limite,
  output logic                  ocupado,
  output estado_t               estado_dbg
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-3:0] DEPTH_IDX = (ADDR_WIDTH-2)'(DEPTH);
  localparam estado_t ESTADO_RESET = (CLEAR_ON_RESET != 0) ? LIMPANDO : PRONTO;

  // ---------------------------------------------------------------- state
  estado_t          r_estado, w_estado_prox;
  logic [IDX_W-1:0] r_cont, w_cont_prox;
  logic [ADDR_WIDTH-1:0] r_offset;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // ------------------------------------------------------ address decode
  logic [ADDR_WIDTH-1:0] w_ea;
  logic [ADDR_WIDTH-3:0] w_idx_full;
  logic [IDX_W-1:0]      w_idx;
  logic [1:0]            w_lane;
  logic                  w_acesso;
  logic                  w_desalinhado;
  logic                  w_fora;
  logic                  w_ok;

  // The offset register value from before this edge is used, so a
  // same-cycle set_offset only affects later accesses.
  assign w_ea       = endereco + r_offset;
  assign w_idx_full = w_ea[ADDR_WIDTH-1:2];
  assign w_idx      = w_idx_full[IDX_W-1:0];
  assign w_lane     = w_ea[1:0];
  assign w_acesso   = (r_estado == PRONTO) && (re || we);

  always_comb begin
    w_desalinhado = 1'b0;
    case (tamanho)
      TAM_BYTE: w_desalinhado = 1'b0;
      TAM_HALF: w_desalinhado = w_lane[0];
      default:  w_desalinhado = (w_lane != 2'b00);
    endcase
  end

  // Misalignment wins: a misaligned out-of-range access reports only the
  // alignment error.
  assign w_fora = !w_desalinhado && (w_idx_full >= DEPTH_IDX);
  assign w_ok   = !w_desalinhado && (w_idx_full < DEPTH_IDX);

  // ------------------------------------------------------- store merge
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [DATA_WIDTH-1:0] w_dado_rep;
  logic [DATA_WIDTH-1:0] w_palavra_atual;
  logic [DATA_WIDTH-1:0] w_mesclada;
  logic                  w_escreve_acc;
  logic [DATA_WIDTH-1:0] w_palavra_leitura;

  assign w_be = gera_be(tamanho, w_lane);

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < 4; i++) begin
      w_mask[8*i +: 8] = {8{w_be[i]}};
    end
  end

  // Replicating the store data across the word lets the lane mask alone
  // place it, whatever the lane.
  always_comb begin
    w_dado_rep = data;
    case (tamanho)
      TAM_BYTE: w_dado_rep = {4{data[7:0]}};
      TAM_HALF: w_dado_rep = {2{data[15:0]}};
      default:  w_dado_rep = data;
    endcase
  end

  // Index is only meaningful when the access is in range.
  always_comb begin
    w_palavra_atual = '0;
    if (w_ok) begin
      w_palavra_atual = r_mem[w_idx];
    end
  end

  assign w_mesclada    = (w_palavra_atual & ~w_mask) | (w_dado_rep & w_mask);
  assign w_escreve_acc = w_acesso && we && w_ok;

  // Write-first: a simultaneous read sees the word as it will be stored.
  assign w_palavra_leitura = w_escreve_acc ? w_mesclada : w_palavra_atual;

  // -------------------------------------------------------- array port
  logic                  w_mem_we;
  logic [IDX_W-1:0]      w_mem_idx;
  logic [DATA_WIDTH-1:0] w_mem_dado;

  always_comb begin
    w_mem_we   = w_escreve_acc;
    w_mem_idx  = w_idx;
    w_mem_dado = w_mesclada;
    if (r_estado == LIMPANDO) begin
      w_mem_we   = 1'b1;
      w_mem_idx  = r_cont;
      w_mem_dado = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_dado;
    end
  end

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= ESTADO_RESET;
      r_cont   <= '0;
    end else begin
      r_estado <= w_estado_prox;
      r_cont   <= w_cont_prox;
    end
  end

  always_comb begin
    w_estado_prox = r_estado;
    w_cont_prox   = r_cont;
    case (r_estado)
      LIMPANDO: begin
        w_cont_prox = r_cont + IDX_W'(1);
        if (r_cont == IDX_W'(DEPTH - 1)) begin
          w_estado_prox = PRONTO;
          w_cont_prox   = '0;
        end
      end
      default: w_estado_prox = PRONTO;
    endcase
  end

  assign ocupado    = (r_estado == LIMPANDO);
  assign estado_dbg = r_estado;

  // ---------------------------------------------------- offset register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_offset <= '0;
    end else if (set_offset) begin
      r_offset <= offset;
    end
  end

  // ---------------------------------------------------------- load path
  logic [DATA_WIDTH-1:0] w_carga;

  extrator_carga #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_extrator (
    .i_palavra(w_palavra_leitura),
    .i_tamanho(tamanho),
    .i_lane   (w_lane),
    .i_sinal  (sinal),
    .o_carga  (w_carga)
  );

  logic                  r_q1;
  logic [DATA_WIDTH-1:0] r_dado1;
  logic                  r_erro_al;
  logic                  r_erro_lim;

  // First output stage; q holds its value between reads. Error pulses are
  // always one cycle after the access regardless of READ_LATENCY.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dado1    <= '0;
      r_q1       <= 1'b0;
      r_erro_al  <= 1'b0;
      r_erro_lim <= 1'b0;
    end else begin
      r_q1       <= w_acesso && re;
      r_erro_al  <= w_acesso && w_desalinhado;
      r_erro_lim <= w_acesso && w_fora;
      if (w_acesso && re) begin
        r_dado1 <= w_ok ? w_carga : '0;
      end
    end
  end

  assign erro_alinhamento = r_erro_al;
  assign erro_limite      = r_erro_lim;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] r_dado2;
      logic                  r_q2;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_dado2 <= '0;
          r_q2    <= 1'b0;
        end else begin
          r_q2 <= r_q1;
          if (r_q1) begin
            r_dado2 <= r_dado1;
          end
        end
      end

      assign q       = r_dado2;
      assign q_valid = r_q2;
    end else begin : g_lat1
      assign q       = r_dado1;
      assign q_valid = r_q1;
    end
  endgenerate

endmodule

// File: tb/tb_dados_ram_param.sv
// tb_dados_ram_param
// Directed bench for dados_ram_param. Two instances share all inputs: u_dut1
// with READ_LATENCY = 1 and u_dut2 with READ_LATENCY = 2, both DEPTH = 16 with
// the clear sweep enabled. Expected values are hand-computed constants.
module tb_dados_ram_param;
  import dados_ram_pkg::*;

  // ------------------------------------------------------ clock / reset
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic        re, we, sinal, set_offset;
  logic [31:0] endereco, data, offset;
  logic [1:0]  tamanho;

  logic [31:0] q1, q2;
  logic        qv1, qv2, eal1, eal2, elim1, elim2, oc1, oc2;
  estado_t     st1, st2;

  dados_ram_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16),
    .READ_LATENCY(1), .CLEAR_ON_RESET(1)
  ) u_dut1 (
    .clock(clock), .reset_n(reset_n), .re(re), .we(we),
    .endereco(endereco), .tamanho(tamanho), .sinal(sinal), .data(data),
    .set_offset(set_offset), .offset(offset),
    .q(q1), .q_valid(qv1), .erro_alinhamento(eal1), .erro_limite(elim1),
    .ocupado(oc1), .estado_dbg(st1)
  );

  dados_ram_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16),
    .READ_LATENCY(2), .CLEAR_ON_RESET(1)
  ) u_dut2 (
    .clock(clock), .reset_n(reset_n), .re(re), .we(we),
    .endereco(endereco), .tamanho(tamanho), .sinal(sinal), .data(data),
    .set_offset(set_offset), .offset(offset),
    .q(q2), .q_valid(qv2), .erro_alinhamento(eal2), .erro_limite(elim2),
    .ocupado(oc2), .estado_dbg(st2)
  );

  // --------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------ drivers
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    re = 1'b0; we = 1'b0; set_offset = 1'b0; sinal = 1'b0;
    endereco = '0; data = '0; offset = '0; tamanho = TAM_WORD;
  endtask

  // One access cycle followed by the checks for both latencies.
  task automatic acc(input string tag, input logic r, input logic w,
                     input logic so, input logic [31:0] off,
                     input logic [31:0] addr, input logic [1:0] tam,
                     input logic sg, input logic [31:0] d,
                     input logic [31:0] exp, input logic e_al,
                     input logic e_lim);
    re = r; we = w; set_offset = so; offset = off;
    endereco = addr; tamanho = tam; sinal = sg; data = d;
    tick();
    idle_inputs();
    chk({tag, "/eal1"},  32'(eal1),  32'(e_al));
    chk({tag, "/elim1"}, 32'(elim1), 32'(e_lim));
    chk({tag, "/eal2"},  32'(eal2),  32'(e_al));
    chk({tag, "/elim2"}, 32'(elim2), 32'(e_lim));
    chk({tag, "/qv1"},   32'(qv1),   32'(r));
    chk({tag, "/qv2a"},  32'(qv2),   32'(0));
    if (r) begin
      chk({tag, "/q1"}, q1, exp);
      exp_q.push_back(exp);
    end
    tick();
    chk({tag, "/eal_end"},  32'(eal1 | eal2),   32'(0));
    chk({tag, "/elim_end"}, 32'(elim1 | elim2), 32'(0));
    chk({tag, "/qv1_end"},  32'(qv1),           32'(0));
    chk({tag, "/qv2"},      32'(qv2),           32'(r));
    if (r) begin
      chk({tag, "/q2"}, q2, exp_q.pop_front());
    end
  endtask

  task automatic set_off(input logic [31:0] off);
    acc("set_off", 1'b0, 1'b0, 1'b1, off, 32'h0, TAM_WORD, 1'b0, 32'h0,
        32'h0, 1'b0, 1'b0);
  endtask

  // Counts ocupado cycles after reset release; inputs are left as driven.
  task automatic count_sweep(input string tag);
    int   n;
    logic pulsos;
    n = 0;
    pulsos = 1'b0;
    while (oc1 && n < 64) begin
      tick();
      n++;
      pulsos = pulsos | qv1 | qv2 | eal1 | eal2 | elim1 | elim2;
    end
    chk({tag, "/ciclos"}, 32'(n), 32'd16);
    chk({tag, "/oc2"},    32'(oc2), 32'd0);
    chk({tag, "/estado"}, 32'(st1), 32'(PRONTO));
    chk({tag, "/pulsos"}, 32'(pulsos), 32'd0);
  endtask

  // ---------------------------------------------------------- watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  // ----------------------------------------------------------- stimulus
  initial begin
    reset_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clock);
    #1;
    chk("rst/q1",    q1, 32'h0);
    chk("rst/q2",    q2, 32'h0);
    chk("rst/qv",    32'(qv1 | qv2), 32'd0);
    chk("rst/erros", 32'(eal1 | elim1 | eal2 | elim2), 32'd0);
    chk("rst/oc1",   32'(oc1), 32'd1);
    chk("rst/oc2",   32'(oc2), 32'd1);
    chk("rst/estado", 32'(st1), 32'(LIMPANDO));

    @(negedge clock);
    reset_n = 1'b1;
    count_sweep("sweep1");

    acc("clr_rd3C", 1, 0, 0, 0, 32'h3C, TAM_WORD, 0, 0, 32'h0, 0, 0);

    // Loads with sign / zero extension from a stored word.
    acc("st_w10",   0, 1, 0, 0, 32'h10, TAM_WORD, 0, 32'h8899AABB, 0, 0, 0);
    acc("ldb13_s",  1, 0, 0, 0, 32'h13, TAM_BYTE, 1, 0, 32'hFFFFFF88, 0, 0);
    acc("ldb13_z",  1, 0, 0, 0, 32'h13, TAM_BYTE, 0, 0, 32'h00000088, 0, 0);
    acc("ldh12_s",  1, 0, 0, 0, 32'h12, TAM_HALF, 1, 0, 32'hFFFF8899, 0, 0);
    acc("ldb10_s",  1, 0, 0, 0, 32'h10, TAM_BYTE, 1, 0, 32'hFFFFFFBB, 0, 0);
    acc("ldb11_z",  1, 0, 0, 0, 32'h11, TAM_BYTE, 0, 0, 32'h000000AA, 0, 0);

    // Partial stores preserve unselected bytes.
    acc("st_wff",   0, 1, 0, 0, 32'h10, TAM_WORD, 0, 32'hFFFFFFFF, 0, 0, 0);
    acc("st_h12",   0, 1, 0, 0, 32'h12, TAM_HALF, 0, 32'h00001234, 0, 0, 0);
    acc("ld_w10a",  1, 0, 0, 0, 32'h10, TAM_WORD, 0, 0, 32'h1234FFFF, 0, 0);
    acc("st_b11",   0, 1, 0, 0, 32'h11, TAM_BYTE, 0, 32'h123456A5, 0, 0, 0);
    acc("ld_w10b",  1, 0, 0, 0, 32'h10, TAM_WORD, 0, 0, 32'h1234A5FF, 0, 0);

    // Offset register, old offset used on a same-cycle load, wraparound.
    set_off(32'h20);
    acc("st_off",   0, 1, 0, 0, 32'h4, TAM_WORD, 0, 32'hCAFEF00D, 0, 0, 0);
    acc("same_off", 1, 0, 1, 32'h0, 32'h4, TAM_WORD, 0, 0, 32'hCAFEF00D, 0, 0);
    acc("ld_24",    1, 0, 0, 0, 32'h24, TAM_WORD, 0, 0, 32'hCAFEF00D, 0, 0);
    acc("ld_04",    1, 0, 0, 0, 32'h04, TAM_WORD, 0, 0, 32'h00000000, 0, 0);
    set_off(32'hFFFFFFFC);
    acc("wrap",     1, 0, 0, 0, 32'h28, TAM_WORD, 0, 0, 32'hCAFEF00D, 0, 0);
    set_off(32'h0);
    acc("rsv_tam",  1, 0, 0, 0, 32'h24, 2'b11, 1, 0, 32'hCAFEF00D, 0, 0);

    // Alignment errors.
    acc("st_w04",   0, 1, 0, 0, 32'h4, TAM_WORD, 0, 32'h11223344, 0, 0, 0);
    acc("mis_rd6",  1, 0, 0, 0, 32'h6, TAM_WORD, 0, 0, 32'h0, 1, 0);
    acc("mis_wr6",  0, 1, 0, 0, 32'h6, TAM_WORD, 0, 32'hDEADBEEF, 0, 1, 0);
    acc("mis_chk",  1, 0, 0, 0, 32'h4, TAM_WORD, 0, 0, 32'h11223344, 0, 0);
    acc("mis_h5",   1, 0, 0, 0, 32'h5, TAM_HALF, 1, 0, 32'h0, 1, 0);
    acc("ldh6",     1, 0, 0, 0, 32'h6, TAM_HALF, 0, 0, 32'h00001122, 0, 0);
    acc("ldb7",     1, 0, 0, 0, 32'h7, TAM_BYTE, 1, 0, 32'h00000011, 0, 0);

    // Range errors and the last in-range byte.
    acc("st_w00",   0, 1, 0, 0, 32'h0, TAM_WORD, 0, 32'h0BADF00D, 0, 0, 0);
    acc("lim_wr40", 0, 1, 0, 0, 32'h40, TAM_WORD, 0, 32'hFFFFFFFF, 0, 0, 1);
    acc("lim_rd40", 1, 0, 0, 0, 32'h40, TAM_WORD, 0, 0, 32'h0, 0, 1);
    acc("lim_chk",  1, 0, 0, 0, 32'h0, TAM_WORD, 0, 0, 32'h0BADF00D, 0, 0);
    acc("mis_pri",  1, 0, 0, 0, 32'h42, TAM_WORD, 0, 0, 32'h0, 1, 0);
    acc("ldb3F",    1, 0, 0, 0, 32'h3F, TAM_BYTE, 1, 0, 32'h0, 0, 0);
    acc("lim_b43",  1, 0, 0, 0, 32'h43, TAM_BYTE, 0, 0, 32'h0, 0, 1);

    // Read and write in the same cycle: write-first.
    acc("rw_w20",   1, 1, 0, 0, 32'h20, TAM_WORD, 0, 32'h55AA55AA, 32'h55AA55AA, 0, 0);
    acc("rw_b21",   1, 1, 0, 0, 32'h21, TAM_BYTE, 1, 32'h00000080, 32'hFFFFFF80, 0, 0);
    acc("ld_w20",   1, 0, 0, 0, 32'h20, TAM_WORD, 0, 0, 32'h55AA80AA, 0, 0);
    acc("rw_mis",   1, 1, 0, 0, 32'h22, TAM_WORD, 0, 32'h00000001, 32'h0, 1, 0);
    acc("ld_w20b",  1, 0, 0, 0, 32'h20, TAM_WORD, 0, 0, 32'h55AA80AA, 0, 0);

    // Back-to-back reads, then q holds.
    re = 1'b1; endereco = 32'h20; tamanho = TAM_WORD;
    tick();
    chk("b2b/qv1a", 32'(qv1), 32'd1);
    chk("b2b/q1a",  q1, 32'h55AA80AA);
    chk("b2b/qv2a", 32'(qv2), 32'd0);
    endereco = 32'h24;
    tick();
    chk("b2b/qv1b", 32'(qv1), 32'd1);
    chk("b2b/q1b",  q1, 32'hCAFEF00D);
    chk("b2b/qv2b", 32'(qv2), 32'd1);
    chk("b2b/q2b",  q2, 32'h55AA80AA);
    idle_inputs();
    tick();
    chk("b2b/qv1c",  32'(qv1), 32'd0);
    chk("hold/q1",   q1, 32'hCAFEF00D);
    chk("b2b/qv2c",  32'(qv2), 32'd1);
    chk("b2b/q2c",   q2, 32'hCAFEF00D);
    tick();
    chk("b2b/qv2d",  32'(qv2), 32'd0);
    chk("hold/q2",   q2, 32'hCAFEF00D);

    // Reset in the middle of a sweep restarts it; accesses during the
    // sweep are dropped, set_offset is still taken.
    reset_n = 1'b0;
    #1;
    chk("rst2/oc",  32'(oc1), 32'd1);
    chk("rst2/q1",  q1, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) tick();
    chk("mid/oc",   32'(oc1), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid/estado", 32'(st1), 32'(LIMPANDO));
    re = 1'b1; we = 1'b1; endereco = 32'h0; tamanho = TAM_WORD;
    data = 32'hFFFFFFFF; set_offset = 1'b1; offset = 32'h4;
    @(negedge clock);
    reset_n = 1'b1;
    count_sweep("sweep2");
    idle_inputs();

    acc("off_sweep", 0, 1, 0, 0, 32'h0, TAM_WORD, 0, 32'h600DCAFE, 0, 0, 0);
    set_off(32'h0);
    acc("ld_sw04",  1, 0, 0, 0, 32'h4,  TAM_WORD, 0, 0, 32'h600DCAFE, 0, 0);
    acc("ld_sw00",  1, 0, 0, 0, 32'h0,  TAM_WORD, 0, 0, 32'h0, 0, 0);
    acc("ld_sw20",  1, 0, 0, 0, 32'h20, TAM_WORD, 0, 0, 32'h0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
